// File: rtl/env_generator_if.sv
// Controller <-> envelope generator handshake: start strobe with register fields,
// and a ready pulse carrying the envelope level back.
interface env_generator_if;
  logic       env_start_i;
  logic [1:0] voice_idx_i;
  logic       env_gate_i;
  logic [3:0] env_attack_i;
  logic [3:0] env_decay_i;
  logic [3:0] env_sustain_i;
  logic [3:0] env_release_i;
  logic       env_ready_o;
  logic [7:0] env_level_o;
  logic       env_busy_o;

  modport master (
    output env_start_i, voice_idx_i, env_gate_i,
           env_attack_i, env_decay_i, env_sustain_i, env_release_i,
    input  env_ready_o, env_level_o, env_busy_o
  );

  modport slave (
    input  env_start_i, voice_idx_i, env_gate_i,
           env_attack_i, env_decay_i, env_sustain_i, env_release_i,
    output env_ready_o, env_level_o, env_busy_o
  );
endinterface

// File: rtl/env_generator.sv
// Time-multiplexed ADSR envelope generator: each start advances one voice's
// envelope by one sample period and returns its 8-bit level after three cycles.
module env_generator #(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  env_generator_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_WRITE} state_t;
  typedef enum logic [1:0] {PH_ATTACK, PH_DECAY, PH_RELEASE} phase_t;

  function automatic logic [ACC_W-1:0] inc_lut(input logic [3:0] rate);
    case (rate)
      4'd0:    inc_lut = ACC_W'(32768);
      4'd1:    inc_lut = ACC_W'(16384);
      4'd2:    inc_lut = ACC_W'(8192);
      4'd3:    inc_lut = ACC_W'(5461);
      4'd4:    inc_lut = ACC_W'(3449);
      4'd5:    inc_lut = ACC_W'(2341);
      4'd6:    inc_lut = ACC_W'(1928);
      4'd7:    inc_lut = ACC_W'(1638);
      4'd8:    inc_lut = ACC_W'(1311);
      4'd9:    inc_lut = ACC_W'(524);
      4'd10:   inc_lut = ACC_W'(262);
      4'd11:   inc_lut = ACC_W'(164);
      4'd12:   inc_lut = ACC_W'(131);
      4'd13:   inc_lut = ACC_W'(44);
      4'd14:   inc_lut = ACC_W'(26);
      default: inc_lut = ACC_W'(16);
    endcase
  endfunction

  state_t r_state, w_state_nxt;
  logic   w_busy, w_load, w_calc, w_write;

  // Per-voice slots
  logic [7:0]       r_lvl_mem [NUM_VOICES];
  logic [ACC_W-1:0] r_acc_mem [NUM_VOICES];
  phase_t           r_ph_mem  [NUM_VOICES];
  logic             r_pg_mem  [NUM_VOICES];

  // Request latched at start
  logic [1:0] r_idx;
  logic       r_valid, r_gate;
  logic [3:0] r_att, r_dec, r_sus, r_rel;

  // Working copy of the selected slot
  logic [7:0]       r_w_lvl;
  logic [ACC_W-1:0] r_w_acc;
  phase_t           r_w_ph;
  logic             r_w_pg;

  logic       r_ready;
  logic [7:0] r_level;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.env_start_i) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_WRITE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_load  = (r_state == S_READ);
    w_calc  = (r_state == S_CALC);
    w_write = (r_state == S_WRITE);
  end

  // ---------------- next-state envelope math ----------------
  logic             w_rise, w_fall, w_carry;
  phase_t           w_ph_e, w_ph_n;
  logic [ACC_W-1:0] w_acc_e, w_acc_n;
  logic [3:0]       w_rate;
  logic [7:0]       w_tgt, w_lvl_n;

  always_comb begin
    w_rise  = r_gate & ~r_w_pg;
    w_fall  = ~r_gate & r_w_pg;
    w_ph_e  = r_w_ph;
    w_acc_e = r_w_acc;
    // A gate edge restarts the rate phase but keeps the current level
    if (w_rise) begin
      w_ph_e  = PH_ATTACK;
      w_acc_e = '0;
    end else if (w_fall) begin
      w_ph_e  = PH_RELEASE;
      w_acc_e = '0;
    end
    case (w_ph_e)
      PH_ATTACK: w_rate = r_att;
      PH_DECAY:  w_rate = r_dec;
      default:   w_rate = r_rel;
    endcase
    {w_carry, w_acc_n} = {1'b0, w_acc_e} + {1'b0, inc_lut(w_rate)};
    w_tgt   = {r_sus, r_sus};
    w_lvl_n = r_w_lvl;
    w_ph_n  = w_ph_e;
    case (w_ph_e)
      PH_ATTACK: begin
        if (w_carry && r_w_lvl != 8'hFF) w_lvl_n = r_w_lvl + 8'd1;
        if (w_lvl_n == 8'hFF) w_ph_n = PH_DECAY;
      end
      PH_DECAY: begin
        if (w_carry && r_w_lvl > w_tgt) w_lvl_n = r_w_lvl - 8'd1;
      end
      default: begin
        if (w_carry && r_w_lvl != 8'd0) w_lvl_n = r_w_lvl - 8'd1;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_level <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_gate  <= 1'b0;
      r_att   <= '0;
      r_dec   <= '0;
      r_sus   <= '0;
      r_rel   <= '0;
      r_w_lvl <= '0;
      r_w_acc <= '0;
      r_w_ph  <= PH_RELEASE;
      r_w_pg  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_lvl_mem[v] <= '0;
        r_acc_mem[v] <= '0;
        r_ph_mem[v]  <= PH_RELEASE;
        r_pg_mem[v]  <= 1'b0;
      end
    end else begin
      r_ready <= 1'b0;
      if (r_state == S_IDLE && bus.env_start_i) begin
        r_idx   <= bus.voice_idx_i;
        r_valid <= (32'(bus.voice_idx_i) < NUM_VOICES);
        r_gate  <= bus.env_gate_i;
        r_att   <= bus.env_attack_i;
        r_dec   <= bus.env_decay_i;
        r_sus   <= bus.env_sustain_i;
        r_rel   <= bus.env_release_i;
      end
      if (w_load) begin
        if (r_valid) begin
          r_w_lvl <= r_lvl_mem[r_idx];
          r_w_acc <= r_acc_mem[r_idx];
          r_w_ph  <= r_ph_mem[r_idx];
          r_w_pg  <= r_pg_mem[r_idx];
        end else begin
          r_w_lvl <= '0;
          r_w_acc <= '0;
          r_w_ph  <= PH_RELEASE;
          r_w_pg  <= 1'b0;
        end
      end
      if (w_calc) begin
        r_w_lvl <= w_lvl_n;
        r_w_acc <= w_acc_n;
        r_w_ph  <= w_ph_n;
        r_w_pg  <= r_gate;
      end
      if (w_write) begin
        r_ready <= 1'b1;
        r_level <= r_valid ? r_w_lvl : 8'd0;
        if (r_valid) begin
          r_lvl_mem[r_idx] <= r_w_lvl;
          r_acc_mem[r_idx] <= r_w_acc;
          r_ph_mem[r_idx]  <= r_w_ph;
          r_pg_mem[r_idx]  <= r_w_pg;
        end
      end
    end
  end

  assign bus.env_ready_o = r_ready;
  assign bus.env_level_o = r_level;
  assign bus.env_busy_o  = w_busy;
endmodule

// File: tb/tb_env_generator.sv
// Directed bench for env_generator: handshake timing, ADSR ramps, voice
// isolation, busy-start rejection, out-of-range index and mid-update reset.
module tb_env_generator;
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  env_generator_if bus();
  env_generator #(.NUM_VOICES(3), .ACC_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int vecs = 0;
  int errs = 0;
  logic [7:0] lvl;
  int lat, bc, rc;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One update; returns level, edges from acceptance to ready, and busy cycles seen.
  task automatic upd(input logic [1:0] idx, input logic g,
                     input logic [3:0] a, input logic [3:0] d,
                     input logic [3:0] s, input logic [3:0] r);
    bus.voice_idx_i = idx; bus.env_gate_i = g;
    bus.env_attack_i = a; bus.env_decay_i = d;
    bus.env_sustain_i = s; bus.env_release_i = r;
    bus.env_start_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.env_start_i = 1'b0;
    lat = 0; bc = 0;
    while (!bus.env_ready_o && lat < 10) begin
      if (bus.env_busy_o) bc++;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    lvl = bus.env_level_o;
  endtask

  task automatic upd_n(input int n, input logic [1:0] idx, input logic g,
                       input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] r);
    for (int i = 0; i < n; i++) upd(idx, g, a, d, s, r);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (bus.env_ready_o !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b expected 0", bus.env_ready_o); end
    vecs++; if (bus.env_level_o !== 8'd0) begin errs++; $display("FAIL reset_level: got %0d expected 0", bus.env_level_o); end
    vecs++; if (bus.env_busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.env_busy_o); end
    for (int v = 0; v < 3; v++) begin
      upd(2'(v), 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      vecs++; if (lat !== 3) begin errs++; $display("FAIL latency_v%0d: got %0d expected 3", v, lat); end
      vecs++; if (bc !== 3) begin errs++; $display("FAIL busy_cycles_v%0d: got %0d expected 3", v, bc); end
      vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL idle_level_v%0d: got %0d expected 0", v, lvl); end
    end
    @(negedge clk);
    vecs++; if (bus.env_ready_o !== 1'b0) begin errs++; $display("FAIL ready_width: got %b expected 0", bus.env_ready_o); end
  endtask

  task automatic test_attack;
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL attack_u1: got %0d expected 0", lvl); end
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd1) begin errs++; $display("FAIL attack_u2: got %0d expected 1", lvl); end
    upd_n(508, 2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd255) begin errs++; $display("FAIL attack_peak: got %0d expected 255", lvl); end
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd255) begin errs++; $display("FAIL decay_u1: got %0d expected 255", lvl); end
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd254) begin errs++; $display("FAIL decay_u2: got %0d expected 254", lvl); end
  endtask

  task automatic test_decay;
    upd_n(236, 2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd136) begin errs++; $display("FAIL decay_sustain: got %0d expected 136", lvl); end
    upd_n(1000, 2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
    vecs++; if (lvl !== 8'd136) begin errs++; $display("FAIL sustain_hold: got %0d expected 136", lvl); end
    upd_n(20, 2'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd136) begin errs++; $display("FAIL sustain_raise: got %0d expected 136", lvl); end
  endtask

  task automatic test_release;
    upd_n(2, 2'd0, 1'b0, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd135) begin errs++; $display("FAIL release_u2: got %0d expected 135", lvl); end
    upd_n(270, 2'd0, 1'b0, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL release_floor: got %0d expected 0", lvl); end
    upd_n(10, 2'd0, 1'b0, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL release_clamp: got %0d expected 0", lvl); end
  endtask

  task automatic test_interleave;
    logic [7:0] l0, l1, l2;
    l0 = '0; l1 = '0; l2 = '0;
    for (int i = 0; i < 64; i++) begin
      upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0); l0 = lvl;
      upd(2'd1, 1'b1, 4'd1, 4'd0, 4'd15, 4'd0); l1 = lvl;
      upd(2'd2, 1'b1, 4'd2, 4'd0, 4'd15, 4'd0); l2 = lvl;
    end
    vecs++; if (l0 !== 8'd32) begin errs++; $display("FAIL interleave_v0: got %0d expected 32", l0); end
    vecs++; if (l1 !== 8'd16) begin errs++; $display("FAIL interleave_v1: got %0d expected 16", l1); end
    vecs++; if (l2 !== 8'd8) begin errs++; $display("FAIL interleave_v2: got %0d expected 8", l2); end
  endtask

  task automatic test_back_to_back;
    // Start held high through the whole update: only one must be accepted
    bus.voice_idx_i = 2'd1; bus.env_gate_i = 1'b1; bus.env_attack_i = 4'd1;
    bus.env_start_i = 1'b1;
    rc = 0; lvl = 8'hxx;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 3) bus.env_start_i = 1'b0;
      if (bus.env_ready_o) begin rc++; lvl = bus.env_level_o; end
    end
    vecs++; if (rc !== 1) begin errs++; $display("FAIL busy_start_pulses: got %0d expected 1", rc); end
    vecs++; if (lvl !== 8'd16) begin errs++; $display("FAIL busy_start_level: got %0d expected 16", lvl); end
    upd_n(3, 2'd1, 1'b1, 4'd1, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd17) begin errs++; $display("FAIL busy_start_acc: got %0d expected 17", lvl); end
  endtask

  task automatic test_bad_index;
    upd(2'd3, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL idx3_latency: got %0d expected 3", lat); end
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL idx3_level: got %0d expected 0", lvl); end
    upd(2'd2, 1'b1, 4'd2, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd8) begin errs++; $display("FAIL idx3_v2_intact: got %0d expected 8", lvl); end
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd32) begin errs++; $display("FAIL idx3_v0_intact: got %0d expected 32", lvl); end
    upd(2'd1, 1'b1, 4'd1, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd17) begin errs++; $display("FAIL idx3_v1_intact: got %0d expected 17", lvl); end
  endtask

  task automatic test_reset_in_calc;
    bus.voice_idx_i = 2'd0; bus.env_gate_i = 1'b1; bus.env_attack_i = 4'd0;
    bus.env_start_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.env_start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    rc = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.env_ready_o) rc++;
      @(posedge clk); @(negedge clk);
    end
    vecs++; if (rc !== 0) begin errs++; $display("FAIL calc_reset_ready: got %0d pulses expected 0", rc); end
    vecs++; if (bus.env_busy_o !== 1'b0) begin errs++; $display("FAIL calc_reset_busy: got %b expected 0", bus.env_busy_o); end
    vecs++; if (bus.env_level_o !== 8'd0) begin errs++; $display("FAIL calc_reset_level: got %0d expected 0", bus.env_level_o); end
    upd_n(2, 2'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd1) begin errs++; $display("FAIL calc_reset_v0: got %0d expected 1", lvl); end
    upd(2'd1, 1'b0, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL calc_reset_v1: got %0d expected 0", lvl); end
    upd(2'd2, 1'b0, 4'd0, 4'd0, 4'd15, 4'd0);
    vecs++; if (lvl !== 8'd0) begin errs++; $display("FAIL calc_reset_v2: got %0d expected 0", lvl); end
  endtask

  initial begin
    rst = 1'b1;
    bus.env_start_i = 1'b0; bus.voice_idx_i = '0; bus.env_gate_i = 1'b0;
    bus.env_attack_i = '0; bus.env_decay_i = '0;
    bus.env_sustain_i = '0; bus.env_release_i = '0;
    @(negedge clk);
    test_reset;
    test_attack;
    test_decay;
    test_release;
    test_interleave;
    test_back_to_back;
    test_bad_index;
    test_reset_in_calc;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
